// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR counter run controller.
// Holds the run-state encoding and the run-length convention.
package lfsr_pkg;

    localparam int CNT_W_DEF = 4;

    // A programmed run length of zero means a full 2^CNT_W advances.
    localparam int RUN_LEN_FULL = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_STEP  = 3'd4,
        ST_DONE  = 3'd5
    } lfsr_run_state_t;

endpackage

// File: rtl/lfsr_hit_tracker.sv
// Target-pattern detector for one run: latches the target at run start and
// records a sticky hit flag plus the step count of the first match.
module lfsr_hit_tracker
    import lfsr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_out,
    input  logic             reset,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_target,
    input  logic             i_adv,
    input  logic [CNT_W-1:0] i_lfsr,
    input  logic [CNT_W-1:0] i_steps,
    output logic             o_hit,
    output logic [CNT_W-1:0] o_hit_pos
);

    logic [CNT_W-1:0] r_target;
    logic             r_hit;
    logic [CNT_W-1:0] r_hit_pos;
    logic             w_match;

    assign w_match = i_adv && !r_hit && (i_lfsr == r_target);

    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            r_target  <= '0;
            r_hit     <= 1'b0;
            r_hit_pos <= '0;
        end else if (i_clr) begin
            r_target  <= i_target;
            r_hit     <= 1'b0;
            r_hit_pos <= '0;
        end else if (w_match) begin
            // Only the first match of a run is recorded.
            r_hit     <= 1'b1;
            r_hit_pos <= i_steps;
        end
    end

    assign o_hit     = r_hit;
    assign o_hit_pos = r_hit_pos;

endmodule

// File: rtl/lfsr_run_ctrl.sv
// Run controller for the 4-bit LFSR counter: clear, advance for a programmed
// length with pause/single-step/abort, and report target hit and final value.
//
// state | meaning
// IDLE  | waiting for start, results from last run held
// CLEAR | counter clear asserted for one cycle
// RUN   | one counter advance per cycle
// PAUSE | run frozen, waiting for pause release or a step
// STEP  | single advance issued from PAUSE
// DONE  | run complete, done pulsed on the first cycle here
module lfsr_run_ctrl
    import lfsr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_out,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_pause,
    input  logic             i_step,
    input  logic [CNT_W-1:0] i_run_len,
    input  logic [CNT_W-1:0] i_target,
    input  logic [CNT_W-1:0] i_lfsr_in,
    output logic             o_cnt_clr,
    output logic             o_cnt_en,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_hit,
    output logic [CNT_W-1:0] o_hit_pos,
    output logic [CNT_W-1:0] o_steps,
    output logic [CNT_W-1:0] o_last_val
);

    localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_LEN_FULL = CNT_W'(RUN_LEN_FULL);

    lfsr_run_state_t  r_state;
    lfsr_run_state_t  w_state_nxt;
    logic [CNT_W-1:0] r_steps;
    logic [CNT_W-1:0] r_remain;
    logic [CNT_W-1:0] r_last_val;
    logic             r_done;
    logic             w_idle_like;
    logic             w_start;
    logic             w_adv;
    logic             w_last;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_start     = w_idle_like && i_start && !i_abort;
    // Abort wins over the advance bookkeeping of the cycle it is sampled in.
    assign w_adv       = ((r_state == ST_RUN) || (r_state == ST_STEP)) && !i_abort;
    // Remaining-advances down-counter hits terminal count on the last advance.
    assign w_last      = (r_remain == '0);

    always_comb begin
        w_state_nxt = r_state;
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) w_state_nxt = ST_CLEAR;
                end
                ST_CLEAR: w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_last)       w_state_nxt = ST_DONE;
                    else if (i_pause) w_state_nxt = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (!i_pause)    w_state_nxt = ST_RUN;
                    else if (i_step) w_state_nxt = ST_STEP;
                end
                ST_STEP: begin
                    if (w_last)       w_state_nxt = ST_DONE;
                    else if (i_pause) w_state_nxt = ST_PAUSE;
                    else              w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            r_steps    <= '0;
            r_remain   <= '0;
            r_last_val <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
            if (w_start) begin
                r_steps  <= '0;
                r_remain <= (i_run_len == LP_LEN_FULL) ? '1 : (i_run_len - LP_ONE);
            end else if (w_adv) begin
                r_steps  <= r_steps + LP_ONE;
                r_remain <= r_remain - LP_ONE;
                if (w_last) r_last_val <= i_lfsr_in;
            end
        end
    end

    lfsr_hit_tracker #(
        .CNT_W (CNT_W)
    ) u_hit_tracker (
        .clk_out   (clk_out),
        .reset     (reset),
        .i_clr     (w_start),
        .i_target  (i_target),
        .i_adv     (w_adv),
        .i_lfsr    (i_lfsr_in),
        .i_steps   (r_steps),
        .o_hit     (o_hit),
        .o_hit_pos (o_hit_pos)
    );

    assign o_cnt_clr  = (r_state == ST_CLEAR);
    assign o_cnt_en   = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign o_busy     = (r_state == ST_CLEAR) || (r_state == ST_RUN) ||
                        (r_state == ST_PAUSE) || (r_state == ST_STEP);
    assign o_done     = r_done;
    assign o_steps    = r_steps;
    assign o_last_val = r_last_val;

endmodule

// File: doc/lfsr_run_ctrl.md
# lfsr_run_ctrl

Run controller for the 4-bit LFSR counter datapath. It sequences the counter: clear, then advance for a programmed number of steps, with pause, single-step and abort. While running, it watches the decoded LFSR value for a target pattern and reports the first hit and the final value. It sits between the board switches/buttons and the counter's `clr`/enable inputs, in the divided `clk_out` domain.

## Interface
Parameters:
- `CNT_W`, default 4: width of the counter, LFSR value, step counter and run length.

Ports:
- `clk_out`  in  1: divided system clock; all state updates on its rising edge.
- `reset`  in  1: reset, asynchronous, active-high; clock `clk_out`.
- `start`  in  1: begin a run; sampled in IDLE or DONE only, ignored while busy.
- `abort`  in  1: return to IDLE from any state; highest priority.
- `pause`  in  1: level; freezes the run while high.
- `step`  in  1: one advance while paused.
- `run_len`  in  CNT_W: advances per run, latched at start; 0 means 2^CNT_W.
- `target`  in  CNT_W: pattern to detect, latched at start.
- `lfsr_in`  in  CNT_W: decoded value from the LFSR counter.
- `cnt_clr`  out  1: drives the counter clear.
- `cnt_en`  out  1: counter advance enable.
- `busy`  out  1: high in CLEAR, RUN, PAUSE and STEP.
- `done`  out  1: one-cycle pulse on entering DONE.
- `hit`  out  1: sticky flag; `lfsr_in` equalled `target` during this run.
- `hit_pos`  out  CNT_W: value of `steps` at the first hit.
- `steps`  out  CNT_W: number of advances completed, modulo 2^CNT_W.
- `last_val`  out  CNT_W: `lfsr_in` captured on the final advance.

## Operation
- States: IDLE, CLEAR, RUN, PAUSE, STEP, DONE.
- All control outputs are Moore-decoded from the registered state; no input reaches an output combinationally.
  - `cnt_clr` = CLEAR.
  - `cnt_en` = RUN or STEP.
- Transition priority on every edge: `abort` first, then the state-specific rules below.
- `abort` in any state: go to IDLE.
  - `steps`, `hit`, `hit_pos` and `last_val` keep their values.
  - `done` is not pulsed.
- IDLE/DONE + `start`:
  - Latch `run_len` and `target`.
  - Clear `steps`, `hit`, `hit_pos`.
  - Go to CLEAR.
- CLEAR: exactly one cycle, then RUN.
- RUN:
  - Each cycle is one advance.
  - If this advance is the last one (`steps` == latched length − 1, modulo 2^CNT_W), go to DONE. This takes precedence over `pause`.
  - Otherwise, `pause`=1 goes to PAUSE; else stay in RUN.
- PAUSE:
  - `pause`=0 goes to RUN.
  - `pause`=1 and `step`=1 goes to STEP.
  - Otherwise stay in PAUSE.
- STEP: one advance, then:
  - last advance: DONE;
  - else `pause`=1: PAUSE;
  - else: RUN.
- Every advance cycle (RUN or STEP):
  - `steps` increments by 1 and wraps.
  - If `lfsr_in` == latched target and `hit`=0, set `hit` and load `hit_pos` with the pre-increment `steps`.
  - On the last advance, `last_val` captures `lfsr_in`.
- DONE: holds until `start` or `abort`. `done` is high only in the first DONE cycle.

## Timing
- Reset values: state IDLE; `cnt_clr`, `cnt_en`, `busy`, `done`, `hit` = 0; `steps`, `hit_pos`, `last_val` = 0.
- `start` to `cnt_clr` high: 1 edge. `cnt_en` first high 2 edges after `start` is sampled.
- A run with length N and no pause takes 1 + N cycles of `busy`; `done` pulses on the cycle after the final advance.
- `pause` sampled during a RUN cycle: that cycle still counts as an advance.
- Run length 0: 2^CNT_W advances. `steps` reads 0 at DONE.
- `start` while busy: ignored.
- `start` together with `abort`: abort wins, go to IDLE.
- `step` outside PAUSE: ignored.
- `reset` asserted mid-run: outputs go to reset values immediately, without waiting for an edge.

## Structure
- Shared package `lfsr_pkg`:
  - state enum `lfsr_run_state_t`;
  - `CNT_W_DEF` = 4;
  - helper constant for the run length encoded as 0.
- One natural sub-module, `lfsr_hit_tracker`: comparator plus sticky `hit`/`hit_pos` register, cleared on start and enabled on advance cycles.
- The FSM and `steps` counter stay in the top module.

## Test plan
- Reset, then `start` with `run_len`=5: `cnt_clr` high 1 cycle, `cnt_en` high 5 cycles, `done` pulses once, `steps`=5, `busy` low afterwards.
- `run_len`=0: 16 advances, `steps`=0 at DONE, `done` pulses exactly once.
- `target`=4'b1010 with `lfsr_in` driven by the real counter: `hit`=1 and `hit_pos` equals the step at which 1010 first appeared; later matches do not change `hit_pos`.
- `pause` raised after 2 advances, then 3 `step` pulses, then `pause` dropped, with `run_len`=8: exactly 8 total advances; `cnt_en` is never high in PAUSE.
- `abort` mid-run at step 3: IDLE the next cycle, `steps`=3 retained, no `done`. `start` asserted during the run is ignored.
- Async `reset` mid-run between edges: all outputs clear immediately; the next `start` runs a normal sequence.
